// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state codes,
// grant identifiers, counter width and the arbitration helper.
package fetch_mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BUSY_IF  = 3'd1;
    localparam logic [2:0] ST_BUSY_MEM = 3'd2;
    localparam logic [2:0] ST_RESP_IF  = 3'd3;
    localparam logic [2:0] ST_RESP_MEM = 3'd4;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    localparam int CNT_W = 4;

    // Pick a requester; on a tie the one not served last wins so neither starves.
    function automatic logic pick_grant(input logic if_req_i,
                                        input logic mem_req_i,
                                        input logic last_grant_i);
        logic grant;
        if (if_req_i && mem_req_i) begin
            grant = (last_grant_i == GRANT_IF) ? GRANT_MEM : GRANT_IF;
        end else if (mem_req_i) begin
            grant = GRANT_MEM;
        end else begin
            grant = GRANT_IF;
        end
        return grant;
    endfunction

endpackage

// File: rtl/fetch_mem_arbiter_latency_counter.sv
// Down-counter that times one memory access: loaded with latency-1 at grant,
// decremented while busy, flags zero on the last access cycle.
module latency_counter
    import fetch_mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates a single-port multi-cycle memory between instruction fetch and
// the MEM stage, sequencing each access and stalling the waiting stages.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int MEM_LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [WORD_LENGTH-1:0] if_addr,
    output logic [WORD_LENGTH-1:0] if_rdata,
    output logic                   if_ready,
    input  logic                   mem_rd_en,
    input  logic                   mem_wr_en,
    input  logic [WORD_LENGTH-1:0] mem_addr,
    input  logic [WORD_LENGTH-1:0] mem_wdata,
    output logic [WORD_LENGTH-1:0] mem_rdata,
    output logic                   mem_ready,
    output logic                   freeze_if,
    output logic                   freeze_mem,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [WORD_LENGTH-1:0] sram_addr,
    output logic [WORD_LENGTH-1:0] sram_wdata,
    input  logic [WORD_LENGTH-1:0] sram_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    logic [2:0]             state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic [WORD_LENGTH-1:0] addr_q,       addr_d;
    logic [WORD_LENGTH-1:0] wdata_q,      wdata_d;
    logic                   we_q,         we_d;
    logic [WORD_LENGTH-1:0] if_rdata_q,   if_rdata_d;
    logic [WORD_LENGTH-1:0] mem_rdata_q,  mem_rdata_d;

    logic mem_req_s;
    logic grant_s;
    logic cnt_load_s;
    logic cnt_dec_s;
    logic cnt_zero_s;
    logic busy_s;

    assign mem_req_s = mem_rd_en | mem_wr_en;
    assign grant_s   = pick_grant(if_req, mem_req_s, last_grant_q);

    latency_counter u_latency_counter (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load_s),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IF;
            addr_q       <= {WORD_LENGTH{1'b0}};
            wdata_q      <= {WORD_LENGTH{1'b0}};
            we_q         <= 1'b0;
            if_rdata_q   <= {WORD_LENGTH{1'b0}};
            mem_rdata_q  <= {WORD_LENGTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // Next state: grant in IDLE, count down in BUSY, capture read data on the last cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req_s) begin
                    cnt_load_s   = 1'b1;
                    last_grant_d = grant_s;
                    if (grant_s == GRANT_MEM) begin
                        state_d = ST_BUSY_MEM;
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_wr_en;
                    end else begin
                        state_d = ST_BUSY_IF;
                        addr_d  = if_addr;
                        wdata_d = {WORD_LENGTH{1'b0}};
                        we_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_IF: begin
                if (cnt_zero_s) begin
                    if_rdata_d = sram_rdata;
                    state_d    = ST_RESP_IF;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_BUSY_MEM: begin
                if (cnt_zero_s) begin
                    // Writes leave the last load value visible to the MEM stage.
                    if (!we_q) begin
                        mem_rdata_d = sram_rdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                    state_d = ST_RESP_MEM;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_RESP_IF:  state_d = ST_IDLE;
            ST_RESP_MEM: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign busy_s = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);

    // Outputs decoded from state; memory bus is quiet outside BUSY and stalls drop in reset.
    always_comb begin
        sram_en    = busy_s;
        sram_we    = busy_s & we_q;
        sram_addr  = busy_s ? addr_q  : {WORD_LENGTH{1'b0}};
        sram_wdata = busy_s ? wdata_q : {WORD_LENGTH{1'b0}};
        if_ready   = (state_q == ST_RESP_IF);
        mem_ready  = (state_q == ST_RESP_MEM);
        if_rdata   = if_rdata_q;
        mem_rdata  = mem_rdata_q;
        freeze_if  = rst & if_req    & ~if_ready;
        freeze_mem = rst & mem_req_s & ~mem_ready;
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter with MEM_LATENCY=3.
module tb_fetch_mem_arbiter;

    localparam int WL  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [WL-1:0] if_addr;
    logic [WL-1:0] if_rdata;
    logic          if_ready;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [WL-1:0] mem_addr;
    logic [WL-1:0] mem_wdata;
    logic [WL-1:0] mem_rdata;
    logic          mem_ready;
    logic          freeze_if;
    logic          freeze_mem;
    logic          sram_en;
    logic          sram_we;
    logic [WL-1:0] sram_addr;
    logic [WL-1:0] sram_wdata;
    logic [WL-1:0] sram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_mem_arbiter #(.WORD_LENGTH(WL), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .freeze_if  (freeze_if),
        .freeze_mem (freeze_mem),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    typedef struct {
        logic          ir;
        logic [WL-1:0] ia;
        logic          mr;
        logic          mw;
        logic [WL-1:0] ma;
        logic [WL-1:0] mwd;
        logic [WL-1:0] sr;
        logic          e_if_rdy;
        logic          e_mem_rdy;
        logic          e_en;
        logic          e_we;
        logic [WL-1:0] e_addr;
        logic [WL-1:0] e_wdata;
        logic [WL-1:0] e_if_rdata;
        logic [WL-1:0] e_mem_rdata;
        logic          e_fz_if;
        logic          e_fz_mem;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [WL-1:0] ia,
                       input logic mr, input logic mw,
                       input logic [WL-1:0] ma, input logic [WL-1:0] mwd,
                       input logic [WL-1:0] sr,
                       input logic r_if, input logic r_mem, input logic en, input logic we,
                       input logic [WL-1:0] sa, input logic [WL-1:0] swd,
                       input logic [WL-1:0] ird, input logic [WL-1:0] mrd,
                       input logic fi, input logic fm);
        vec_t v;
        v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd; v.sr = sr;
        v.e_if_rdy = r_if; v.e_mem_rdy = r_mem; v.e_en = en; v.e_we = we;
        v.e_addr = sa; v.e_wdata = swd; v.e_if_rdata = ird; v.e_mem_rdata = mrd;
        v.e_fz_if = fi; v.e_fz_mem = fm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ir, input logic [WL-1:0] ia, input logic mr,
                         input logic mw, input logic [WL-1:0] ma, input logic [WL-1:0] mwd,
                         input logic [WL-1:0] sr);
        if_req = ir; if_addr = ia; mem_rd_en = mr; mem_wr_en = mw;
        mem_addr = ma; mem_wdata = mwd; sram_rdata = sr;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    localparam logic [WL-1:0] D_IF  = 32'hE3A0_0001;
    localparam logic [WL-1:0] D_MEM = 32'hCAFE_F00D;
    localparam logic [WL-1:0] BEEF  = 32'hDEAD_BEEF;

    initial begin
        int seen;

        // Test 1: reset held with every request active.
        rst = 1'b0;
        drive(1'b1, 32'h44, 1'b1, 1'b1, 32'h88, 32'h99, 32'h1234_5678);
        repeat (3) @(negedge clk);
        #1;
        chk("rst if_ready",   {31'h0, if_ready},   32'h0);
        chk("rst mem_ready",  {31'h0, mem_ready},  32'h0);
        chk("rst if_rdata",   if_rdata,            32'h0);
        chk("rst mem_rdata",  mem_rdata,           32'h0);
        chk("rst freeze_if",  {31'h0, freeze_if},  32'h0);
        chk("rst freeze_mem", {31'h0, freeze_mem}, 32'h0);
        chk("rst sram_en",    {31'h0, sram_en},    32'h0);
        chk("rst sram_we",    {31'h0, sram_we},    32'h0);
        chk("rst sram_addr",  sram_addr,           32'h0);
        chk("rst sram_wdata", sram_wdata,          32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d sram_en", c), {31'h0, sram_en}, 32'h0);
        end

        // Tests 2, 3, 5 and write-wins as a cycle table (last_grant=IF, rdata=0).
        // IF read of 0x10
        add(1, 32'h10, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0,           0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0,           0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0);
        add(1, 32'h10, 0, 0, 0, 0, D_IF,        0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0);
        add(1, 32'h10, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, D_IF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, D_IF, 0, 0, 0);
        // MEM write of DEADBEEF to 0x100
        add(0, 0, 0, 1, 32'h100, BEEF, 0,       0, 0, 0, 0, 0, 0, D_IF, 0, 0, 1);
        add(0, 0, 0, 1, 32'h100, BEEF, 0,       0, 0, 1, 1, 32'h100, BEEF, D_IF, 0, 0, 1);
        add(0, 0, 0, 1, 32'h100, BEEF, 0,       0, 0, 1, 1, 32'h100, BEEF, D_IF, 0, 0, 1);
        add(0, 0, 0, 1, 32'h100, BEEF, 32'h12345678, 0, 0, 1, 1, 32'h100, BEEF, D_IF, 0, 0, 1);
        add(0, 0, 0, 1, 32'h100, BEEF, 0,       0, 1, 0, 0, 0, 0, D_IF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, D_IF, 0, 0, 0);
        // MEM read of 0x200, address changes to 0x300 mid-access
        add(0, 0, 1, 0, 32'h200, 0, 0,          0, 0, 0, 0, 0, 0, D_IF, 0, 0, 1);
        add(0, 0, 1, 0, 32'h300, 0, 0,          0, 0, 1, 0, 32'h200, 0, D_IF, 0, 0, 1);
        add(0, 0, 1, 0, 32'h300, 0, 0,          0, 0, 1, 0, 32'h200, 0, D_IF, 0, 0, 1);
        add(0, 0, 1, 0, 32'h300, 0, D_MEM,      0, 0, 1, 0, 32'h200, 0, D_IF, 0, 0, 1);
        add(0, 0, 1, 0, 32'h300, 0, 0,          0, 1, 0, 0, 0, 0, D_IF, D_MEM, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, D_IF, D_MEM, 0, 0);
        // rd and wr together: write wins, mem_rdata unchanged
        add(0, 0, 1, 1, 32'h40, 32'h55, 0,      0, 0, 0, 0, 0, 0, D_IF, D_MEM, 0, 1);
        add(0, 0, 1, 1, 32'h40, 32'h55, 0,      0, 0, 1, 1, 32'h40, 32'h55, D_IF, D_MEM, 0, 1);
        add(0, 0, 1, 1, 32'h40, 32'h55, 0,      0, 0, 1, 1, 32'h40, 32'h55, D_IF, D_MEM, 0, 1);
        add(0, 0, 1, 1, 32'h40, 32'h55, 32'h99, 0, 0, 1, 1, 32'h40, 32'h55, D_IF, D_MEM, 0, 1);
        add(0, 0, 1, 1, 32'h40, 32'h55, 0,      0, 1, 0, 0, 0, 0, D_IF, D_MEM, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, D_IF, D_MEM, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ir, vecs[i].ia, vecs[i].mr, vecs[i].mw,
                  vecs[i].ma, vecs[i].mwd, vecs[i].sr);
            #1;
            chk($sformatf("row%0d if_ready", i),   {31'h0, if_ready},   {31'h0, vecs[i].e_if_rdy});
            chk($sformatf("row%0d mem_ready", i),  {31'h0, mem_ready},  {31'h0, vecs[i].e_mem_rdy});
            chk($sformatf("row%0d sram_en", i),    {31'h0, sram_en},    {31'h0, vecs[i].e_en});
            chk($sformatf("row%0d sram_we", i),    {31'h0, sram_we},    {31'h0, vecs[i].e_we});
            chk($sformatf("row%0d sram_addr", i),  sram_addr,           vecs[i].e_addr);
            chk($sformatf("row%0d sram_wdata", i), sram_wdata,          vecs[i].e_wdata);
            chk($sformatf("row%0d if_rdata", i),   if_rdata,            vecs[i].e_if_rdata);
            chk($sformatf("row%0d mem_rdata", i),  mem_rdata,           vecs[i].e_mem_rdata);
            chk($sformatf("row%0d freeze_if", i),  {31'h0, freeze_if},  {31'h0, vecs[i].e_fz_if});
            chk($sformatf("row%0d freeze_mem", i), {31'h0, freeze_mem}, {31'h0, vecs[i].e_fz_mem});
        end

        // Test 4: simultaneous requests from reset alternate MEM, IF, MEM.
        reset_pulse();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive(1'b1, 32'hA0, 1'b1, 1'b0, 32'hB0, 32'h0, 32'h1111_1111);
            #1;
            case (c)
                0, 5, 10: chk($sformatf("alt c%0d sram_en", c), {31'h0, sram_en}, 32'h0);
                1, 2, 3, 11: chk($sformatf("alt c%0d sram_addr", c), sram_addr, 32'hB0);
                4: begin
                    chk("alt mem_ready", {31'h0, mem_ready}, 32'h1);
                    chk("alt mem_rdata", mem_rdata, 32'h1111_1111);
                end
                6, 7, 8: chk($sformatf("alt c%0d sram_addr", c), sram_addr, 32'hA0);
                9: begin
                    chk("alt if_ready", {31'h0, if_ready}, 32'h1);
                    chk("alt if_rdata", if_rdata, 32'h1111_1111);
                end
                default: ;
            endcase
        end

        // Test 6: reset during BUSY_IF abandons the access.
        reset_pulse();
        @(negedge clk);
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555_5555);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort busy sram_en", {31'h0, sram_en}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort sram_en",  {31'h0, sram_en},  32'h0);
        chk("abort if_ready", {31'h0, if_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555_5555);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (if_ready === 1'b1) seen++;
        end
        chk("abort no pulse", 32'(seen), 32'h0);
        chk("abort if_rdata", if_rdata, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_0077);
            #1;
            if (c >= 1 && c <= 3) begin
                chk($sformatf("fresh c%0d sram_addr", c), sram_addr, 32'h24);
            end else if (c == 4) begin
                chk("fresh if_ready", {31'h0, if_ready}, 32'h1);
                chk("fresh if_rdata", if_rdata, 32'h7777_0077);
            end else begin
                chk("fresh idle sram_en", {31'h0, sram_en}, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
